wb_regfile: RTL and testbench

//  - Write-back consumer of the MEM/WB pipeline register: the GPR file plus the HI/LO pair.
//  - Commits the registered WB-stage bus (wb_wd/wb_wreg/wb_wdata, wb_whilo/wb_hi/wb_lo)
//    on the clock edge.
//  - Serves two combinational read ports to the ID stage, with optional same-cycle WB bypass.
//  - Serves the current HI/LO values to the EX stage.

---
 rtl/wb_regfile_if.sv | 35 +++
 rtl/wb_regfile.sv | 85 ++++++++
 tb/tb_wb_regfile.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/wb_regfile_if.sv
// Write-back / ID / EX side bus of the GPR + HI/LO register file.
// The slave modport belongs to wb_regfile; master is the pipeline side.
interface wb_regfile_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              re1;
  logic [ADDR_W-1:0] raddr1;
  logic [DATA_W-1:0] rdata1;
  logic              re2;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata2;
  logic              whilo;
  logic [DATA_W-1:0] hi_i;
  logic [DATA_W-1:0] lo_i;
  logic [DATA_W-1:0] hi_o;
  logic [DATA_W-1:0] lo_o;

  modport slave (
    input  we, waddr, wdata,
    input  re1, raddr1, re2, raddr2,
    input  whilo, hi_i, lo_i,
    output rdata1, rdata2, hi_o, lo_o
  );

  modport master (
    output we, waddr, wdata,
    output re1, raddr1, re2, raddr2,
    output whilo, hi_i, lo_i,
    input  rdata1, rdata2, hi_o, lo_o
  );
endinterface

// File: rtl/wb_regfile.sv
// GPR file (r0 hardwired to zero) plus HI/LO pair, committed from the WB stage.
// Define WB_BYPASS_EN to forward the write-back data to same-cycle ID reads.
module wb_regfile #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic           clk,
  input  logic           rst,
  wb_regfile_if.slave    bus
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;

  // Writes to address 0 never land, so regs_q[0] stays at its reset value of 0.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (i != 0 && bus.we && bus.waddr == ADDR_W'(i)) begin
        regs_d[i] = bus.wdata;
      end
    end
  end

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (bus.whilo) begin
      hi_d = bus.hi_i;
      lo_d = bus.lo_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  // Read ports: reset, r0 and disabled ports all force zero ahead of any lookup.
  logic              rd_en   [2];
  logic [ADDR_W-1:0] rd_addr [2];
  logic [DATA_W-1:0] rd_data [2];

  assign rd_en[0]   = bus.re1;
  assign rd_en[1]   = bus.re2;
  assign rd_addr[0] = bus.raddr1;
  assign rd_addr[1] = bus.raddr2;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data[p] = '0;
      if (!rst && rd_addr[p] != '0 && rd_en[p]) begin
`ifdef WB_BYPASS_EN
        if (bus.we && bus.waddr == rd_addr[p]) begin
          rd_data[p] = bus.wdata;
        end else begin
          rd_data[p] = regs_q[rd_addr[p]];
        end
`else
        rd_data[p] = regs_q[rd_addr[p]];
`endif
      end
    end
  end

  assign bus.rdata1 = rd_data[0];
  assign bus.rdata2 = rd_data[1];
  assign bus.hi_o   = hi_q;
  assign bus.lo_o   = lo_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_wb_regfile;

  localparam int DW = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst;

  wb_regfile_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  wb_regfile #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

`ifdef WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  int pass_cnt  = 0;
  int check_cnt = 0;
  bit chk_en    = 1'b0;

  // Architectural state as the pipeline sees it.
  logic [DW-1:0] mem [32];
  logic [DW-1:0] m_hi, m_lo;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [DW-1:0] model_read(input logic re, input logic [AW-1:0] ra);
    if (rst || ra == 0 || !re) return '0;
    if (BYPASS && bus.we && bus.waddr == ra) return bus.wdata;
    return mem[ra];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) mem[i] = '0;
      m_hi = '0;
      m_lo = '0;
    end else begin
      if (bus.we && bus.waddr != 0) mem[bus.waddr] = bus.wdata;
      if (bus.whilo) begin
        m_hi = bus.hi_i;
        m_lo = bus.lo_i;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_rdata1", bus.rdata1, model_read(bus.re1, bus.raddr1));
      check("model_rdata2", bus.rdata2, model_read(bus.re2, bus.raddr2));
      check("model_hi", bus.hi_o, m_hi);
      check("model_lo", bus.lo_o, m_lo);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.we = 0; bus.waddr = 0; bus.wdata = 0;
    bus.re1 = 0; bus.raddr1 = 0; bus.re2 = 0; bus.raddr2 = 0;
    bus.whilo = 0; bus.hi_i = 0; bus.lo_i = 0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    idle();
    bus.we = 1; bus.waddr = a; bus.wdata = d;
    step();
    idle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    step();
    step();
    rst = 1'b0;
    chk_en = 1'b1;

    // 1. reset clears pre-loaded state and drops a coincident write
    wr(5, 32'hDEADBEEF);
    bus.whilo = 1; bus.hi_i = 32'h1; bus.lo_i = 32'h2;
    step();
    idle();
    bus.re1 = 1; bus.raddr1 = 5;
    @(negedge clk);
    check("preload_r5", bus.rdata1, 32'hDEADBEEF);
    check("preload_hi", bus.hi_o, 32'h1);
    rst = 1; bus.we = 1; bus.waddr = 5; bus.wdata = 32'hCAFEF00D;
    step();
    check("rst_rdata1", bus.rdata1, 32'h0);
    rst = 0; bus.we = 0;
    @(negedge clk);
    check("rst_r5", bus.rdata1, 32'h0);
    check("rst_hi", bus.hi_o, 32'h0);
    check("rst_lo", bus.lo_o, 32'h0);

    // 2. r0 protection
    idle();
    bus.we = 1; bus.waddr = 0; bus.wdata = 32'h12345678; bus.re1 = 1; bus.raddr1 = 0;
    @(negedge clk);
    check("r0_same", bus.rdata1, 32'h0);
    step();
    bus.we = 0;
    @(negedge clk);
    check("r0_after", bus.rdata1, 32'h0);

    // 3. write then read on both ports, then disable port 2
    wr(7, 32'hA5A5A5A5);
    bus.re1 = 1; bus.raddr1 = 7; bus.re2 = 1; bus.raddr2 = 7;
    @(negedge clk);
    check("r7_port1", bus.rdata1, 32'hA5A5A5A5);
    check("r7_port2", bus.rdata2, 32'hA5A5A5A5);
    bus.re2 = 0;
    @(negedge clk);
    check("re2_off", bus.rdata2, 32'h0);

    // 4. same-cycle WB->ID hazard
    wr(3, 32'h11);
    bus.we = 1; bus.waddr = 3; bus.wdata = 32'h22; bus.re1 = 1; bus.raddr1 = 3;
    @(negedge clk);
    check("hazard_same", bus.rdata1, BYPASS ? 32'h22 : 32'h11);
    step();
    bus.we = 0;
    @(negedge clk);
    check("hazard_next", bus.rdata1, 32'h22);

    // 5. HI/LO together with a GPR write
    idle();
    bus.we = 1; bus.waddr = 9; bus.wdata = 32'h9;
    bus.whilo = 1; bus.hi_i = 32'hFFFF0000; bus.lo_i = 32'h0000FFFF;
    step();
    idle();
    bus.re1 = 1; bus.raddr1 = 9;
    @(negedge clk);
    check("hilo_hi", bus.hi_o, 32'hFFFF0000);
    check("hilo_lo", bus.lo_o, 32'h0000FFFF);
    check("hilo_r9", bus.rdata1, 32'h9);

    // 6. reset mid-operation loses coincident writes
    wr(4, 32'h44);
    rst = 1;
    bus.we = 1; bus.waddr = 4; bus.wdata = 32'h55;
    bus.whilo = 1; bus.hi_i = 32'h66; bus.lo_i = 32'h77;
    step();
    rst = 0;
    idle();
    bus.re2 = 1; bus.raddr2 = 4;
    @(negedge clk);
    check("midrst_r4", bus.rdata2, 32'h0);
    check("midrst_hi", bus.hi_o, 32'h0);
    check("midrst_lo", bus.lo_o, 32'h0);

    // Randomized traffic; the compare process checks every cycle.
    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom_range(0, 99) < 2);
      bus.we    = $urandom_range(0, 1);
      bus.waddr = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
      bus.wdata = $urandom;
      bus.re1   = ($urandom_range(0, 3) != 0);
      bus.raddr1 = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
      bus.re2   = ($urandom_range(0, 3) != 0);
      bus.raddr2 = ($urandom_range(0, 2) == 0) ? bus.waddr : AW'($urandom);
      bus.whilo = ($urandom_range(0, 9) < 3);
      bus.hi_i  = $urandom;
      bus.lo_i  = $urandom;
      step();
    end

    rst = 0;
    idle();
    @(negedge clk);
    #1;
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
